// File: rtl/dram_arb_pkg.sv
// Shared defaults, port-select type and round-robin index helper for the dual-port RAM arbiter.
package dram_arb_pkg;

    localparam int NREQ_DEF   = 4;
    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 10;

    typedef enum logic [1:0] {
        PORT_NONE = 2'd0,
        PORT_1    = 2'd1,
        PORT_2    = 2'd2
    } port_sel_e;

    // Index reached by stepping idx places forward from ptr; ptr < nreq and idx <= nreq.
    function automatic int rr_next(input int ptr, input int idx, input int nreq);
        int sum;
        sum = ptr + idx;
        return (sum >= nreq) ? (sum - nreq) : sum;
    endfunction

endpackage

// File: rtl/dual_ram_arbiter_rr_pick.sv
// Rotating-priority picker: first set request bit at or after ptr, wrapping at NREQ.
module rr_pick
    import dram_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  onehot,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        logic [IDX_W-1:0] cand_idx;
        onehot   = '0;
        idx      = '0;
        valid    = 1'b0;
        cand_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_idx = IDX_W'(rr_next(int'(ptr), k, NREQ));
            if (!valid && req[cand_idx]) begin
                onehot[cand_idx] = 1'b1;
                idx              = cand_idx;
                valid            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dual_ram_syn.sv
// 2**ADDR_W x DATA_W RAM with two synchronous read/write ports, 1-cycle read latency (read-before-write).
module dual_ram_syn #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [DATA_W-1:0] din1,
    input  logic [DATA_W-1:0] din2,
    input  logic              w_en1,
    input  logic              w_en2,
    output logic [DATA_W-1:0] dout1,
    output logic [DATA_W-1:0] dout2
);

    logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (w_en1) r_mem[addr1] <= din1;
        if (w_en2) r_mem[addr2] <= din2;
        dout1 <= r_mem[addr1];
        dout2 <= r_mem[addr2];
    end

endmodule

// File: rtl/dual_ram_arbiter.sv
// Round-robin arbiter granting up to two requesters per cycle onto the two ports of dual_ram_syn.
// Define DRAM_ARB_COLLISION_EN to hold off a second pick that hits the first pick's address with a write.
module dual_ram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          we,
    input  logic [NREQ*ADDR_W-1:0]   addr,
    input  logic [NREQ*DATA_W-1:0]   wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          rvalid,
    output logic [NREQ*DATA_W-1:0]   rdata,
    output logic [ADDR_W-1:0]        addr1,
    output logic [ADDR_W-1:0]        addr2,
    output logic [DATA_W-1:0]        din1,
    output logic [DATA_W-1:0]        din2,
    output logic                     w_en1,
    output logic                     w_en2,
    input  logic [DATA_W-1:0]        dout1,
    input  logic [DATA_W-1:0]        dout2
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IDX_W-1:0]  r_ptr;
    logic [IDX_W-1:0]  w_ptr_next;
    logic              r_tag_v1;
    logic              r_tag_v2;
    logic [IDX_W-1:0]  r_tag_id1;
    logic [IDX_W-1:0]  r_tag_id2;

    logic [ADDR_W-1:0] w_addr_arr [NREQ];
    logic [DATA_W-1:0] w_wdata_arr [NREQ];
    port_sel_e         w_sel [NREQ];

    logic [NREQ-1:0]   w_oh1;
    logic [NREQ-1:0]   w_oh2;
    logic [NREQ-1:0]   w_req2;
    logic [IDX_W-1:0]  w_idx1;
    logic [IDX_W-1:0]  w_idx2;
    logic              w_v1;
    logic              w_v2;
    logic              w_coll;
    logic              w_g2;

    genvar gi;

    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unflat
            assign w_addr_arr[gi]  = addr[gi*ADDR_W +: ADDR_W];
            assign w_wdata_arr[gi] = wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick1 (
        .req    (req),
        .ptr    (r_ptr),
        .onehot (w_oh1),
        .idx    (w_idx1),
        .valid  (w_v1)
    );

    // Masking the first winner makes the second picker return the next requester in rotation.
    assign w_req2 = req & ~w_oh1;

    rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick2 (
        .req    (w_req2),
        .ptr    (r_ptr),
        .onehot (w_oh2),
        .idx    (w_idx2),
        .valid  (w_v2)
    );

`ifdef DRAM_ARB_COLLISION_EN
    assign w_coll = w_v1 && w_v2
                    && (w_addr_arr[w_idx1] == w_addr_arr[w_idx2])
                    && (we[w_idx1] || we[w_idx2]);
`else
    assign w_coll = 1'b0;
`endif

    assign w_g2 = w_v2 && !w_coll;

    assign gnt = rst_n ? (w_oh1 | (w_g2 ? w_oh2 : '0)) : '0;

    assign addr1 = w_v1 ? w_addr_arr[w_idx1]  : '0;
    assign din1  = w_v1 ? w_wdata_arr[w_idx1] : '0;
    assign w_en1 = rst_n && w_v1 && we[w_idx1];

    assign addr2 = w_g2 ? w_addr_arr[w_idx2]  : '0;
    assign din2  = w_g2 ? w_wdata_arr[w_idx2] : '0;
    assign w_en2 = rst_n && w_g2 && we[w_idx2];

    // A held-off second pick is automatically first in line next cycle because ptr lands just past pick 1.
    always_comb begin
        w_ptr_next = r_ptr;
        if (w_g2) begin
            w_ptr_next = IDX_W'(rr_next(int'(w_idx2), 1, NREQ));
        end else if (w_v1) begin
            w_ptr_next = IDX_W'(rr_next(int'(w_idx1), 1, NREQ));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr     <= '0;
            r_tag_v1  <= 1'b0;
            r_tag_v2  <= 1'b0;
            r_tag_id1 <= '0;
            r_tag_id2 <= '0;
        end else begin
            r_ptr     <= w_ptr_next;
            r_tag_v1  <= w_v1 && !we[w_idx1];
            r_tag_v2  <= w_g2 && !we[w_idx2];
            r_tag_id1 <= w_idx1;
            r_tag_id2 <= w_idx2;
        end
    end

    // The two ports never serve the same requester in one cycle, so the port select is unambiguous.
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_route
            assign w_sel[gi] = (r_tag_v1 && (r_tag_id1 == IDX_W'(gi))) ? PORT_1 :
                               (r_tag_v2 && (r_tag_id2 == IDX_W'(gi))) ? PORT_2 :
                                                                         PORT_NONE;
            assign rvalid[gi] = (w_sel[gi] != PORT_NONE);
            assign rdata[gi*DATA_W +: DATA_W] = (w_sel[gi] == PORT_1) ? dout1 :
                                                (w_sel[gi] == PORT_2) ? dout2 :
                                                                        '0;
        end
    endgenerate

endmodule

// File: tb/tb_dual_ram_arbiter.sv
// Directed bench: dual_ram_arbiter driving a dual_ram_syn, hand-computed grants, port pins and read data.
module tb_dual_ram_arbiter;

    localparam int NREQ   = 4;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 10;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        we;
    logic [ADDR_W-1:0]      a [NREQ];
    logic [DATA_W-1:0]      d [NREQ];
    logic [NREQ*ADDR_W-1:0] addr_flat;
    logic [NREQ*DATA_W-1:0] wdata_flat;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        rvalid;
    logic [NREQ*DATA_W-1:0] rdata;
    logic [ADDR_W-1:0]      addr1, addr2;
    logic [DATA_W-1:0]      din1, din2, dout1, dout2;
    logic                   w_en1, w_en2;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    assign addr_flat  = {a[3], a[2], a[1], a[0]};
    assign wdata_flat = {d[3], d[2], d[1], d[0]};

    dual_ram_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .we     (we),
        .addr   (addr_flat),
        .wdata  (wdata_flat),
        .gnt    (gnt),
        .rvalid (rvalid),
        .rdata  (rdata),
        .addr1  (addr1),
        .addr2  (addr2),
        .din1   (din1),
        .din2   (din2),
        .w_en1  (w_en1),
        .w_en2  (w_en2),
        .dout1  (dout1),
        .dout2  (dout2)
    );

    dual_ram_syn #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .addr1 (addr1),
        .addr2 (addr2),
        .din1  (din1),
        .din2  (din2),
        .w_en1 (w_en1),
        .w_en2 (w_en2),
        .dout1 (dout1),
        .dout2 (dout2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rd(input int k);
        return rdata[k*DATA_W +: DATA_W];
    endfunction

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic show(input string name);
        @(negedge clk);
        $display("[%0t] %s req=%b we=%b gnt=%b rvalid=%b", $time, name, req, we, gnt, rvalid);
    endtask

    initial begin
        req = 4'b1111;
        we  = 4'b1111;
        a[0] = 10'd5; a[1] = 10'd6; a[2] = 10'd7; a[3] = 10'd8;
        d[0] = 8'd1;  d[1] = 8'd2;  d[2] = 8'd3;  d[3] = 8'd4;

        // reset held with every requester asking to write
        show("reset");
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_wen1", w_en1, 1'b0);
        chk("rst_wen2", w_en2, 1'b0);
        chk("rst_rvalid", rvalid, 4'b0000);
        chk("rst_rdata", rdata, 32'd0);

        // release: all read, ptr=0 -> req0 on port1, req1 on port2
        adv(); rst_n = 1'b1; we = 4'b0000;
        show("first_grant");
        chk("s1_gnt", gnt, 4'b0011);
        chk("s1_addr1", addr1, 10'd5);
        chk("s1_addr2", addr2, 10'd6);
        chk("s1_wen1", w_en1, 1'b0);

        // writes; ptr=2 but only 0/1 request
        adv(); req = 4'b0011; we = 4'b0011;
        a[0] = 10'd1001; d[0] = 8'd210; a[1] = 10'd999; d[1] = 8'd110;
        show("write");
        chk("s2_rvalid", rvalid, 4'b0011);
        chk("s2_gnt", gnt, 4'b0011);
        chk("s2_addr1", addr1, 10'd1001);
        chk("s2_din1", din1, 8'd210);
        chk("s2_wen1", w_en1, 1'b1);
        chk("s2_addr2", addr2, 10'd999);
        chk("s2_din2", din2, 8'd110);
        chk("s2_wen2", w_en2, 1'b1);

        adv(); we = 4'b0000;
        show("readback");
        chk("s3_rvalid", rvalid, 4'b0000);
        chk("s3_gnt", gnt, 4'b0011);

        // req3 alone moves ptr from 2 to 0
        adv(); req = 4'b1000;
        a[0] = 10'd5; a[1] = 10'd6;
        show("ptr_align");
        chk("s4_rvalid", rvalid, 4'b0011);
        chk("s4_rdata0", rd(0), 8'd210);
        chk("s4_rdata1", rd(1), 8'd110);
        chk("s4_gnt", gnt, 4'b1000);

        // fairness: all four hold reads
        adv(); req = 4'b1111;
        show("fair0");
        chk("f0_rvalid", rvalid, 4'b1000);
        chk("f0_gnt", gnt, 4'b0011);
        adv();
        show("fair1");
        chk("f1_rvalid", rvalid, 4'b0011);
        chk("f1_gnt", gnt, 4'b1100);
        chk("f1_addr1", addr1, 10'd7);
        adv();
        show("fair2");
        chk("f2_rvalid", rvalid, 4'b1100);
        chk("f2_gnt", gnt, 4'b0011);
        adv();
        show("fair3");
        chk("f3_rvalid", rvalid, 4'b0011);
        chk("f3_gnt", gnt, 4'b1100);

        // ptr back at 0: req0 is first pick over req3
        adv(); req = 4'b1001;
        show("ptr_zero");
        chk("p0_rvalid", rvalid, 4'b1100);
        chk("p0_gnt", gnt, 4'b1001);
        chk("p0_addr1", addr1, 10'd5);
        chk("p0_addr2", addr2, 10'd8);

        // req2 writes 140@1000 while req3 reads @1000
        adv(); req = 4'b1100; we = 4'b0100;
        a[2] = 10'd1000; d[2] = 8'd140; a[3] = 10'd1000;
        show("collide");
        chk("c0_rvalid", rvalid, 4'b1001);
        chk("c0_addr1", addr1, 10'd1000);
        chk("c0_din1", din1, 8'd140);
        chk("c0_wen1", w_en1, 1'b1);
        chk("c0_wen2", w_en2, 1'b0);
`ifdef DRAM_ARB_COLLISION_EN
        chk("c0_gnt", gnt, 4'b0100);
        chk("c0_addr2", addr2, 10'd0);
        adv(); req = 4'b1000; we = 4'b0000;
        show("collide_retry");
        chk("c1_gnt", gnt, 4'b1000);
        chk("c1_addr1", addr1, 10'd1000);
        chk("c1_rvalid", rvalid, 4'b0000);
        adv(); req = 4'b0000;
        show("collide_data");
        chk("c2_rvalid", rvalid, 4'b1000);
        chk("c2_rdata3", rd(3), 8'd140);
`else
        chk("c0_gnt", gnt, 4'b1100);
        chk("c0_addr2", addr2, 10'd1000);
        adv(); req = 4'b0000; we = 4'b0000;
        show("collide_done");
        chk("c1_gnt", gnt, 4'b0000);
        chk("c1_rvalid", rvalid, 4'b1000);
        adv();
        show("collide_idle");
        chk("c2_rvalid", rvalid, 4'b0000);
`endif

        // read granted, reset before its data would be consumed
        adv(); req = 4'b0001; we = 4'b0000; a[0] = 10'd999;
        show("pre_reset_read");
        chk("m0_gnt", gnt, 4'b0001);
        adv(); rst_n = 1'b0; req = 4'b0000;
        show("mid_reset");
        chk("m1_rvalid", rvalid, 4'b0000);
        chk("m1_rdata", rdata, 32'd0);
        adv(); rst_n = 1'b1;
        show("post_reset");
        chk("m2_rvalid", rvalid, 4'b0000);
        chk("m2_gnt", gnt, 4'b0000);

        // back-to-back reads from req0; RAM contents survive arbiter reset
        adv(); req = 4'b0001; a[0] = 10'd1001;
        show("b2b0");
        chk("b0_gnt", gnt, 4'b0001);
        chk("b0_rvalid", rvalid, 4'b0000);
        adv(); a[0] = 10'd999;
        show("b2b1");
        chk("b1_gnt", gnt, 4'b0001);
        chk("b1_rvalid", rvalid, 4'b0001);
        chk("b1_rdata0", rd(0), 8'd210);
        adv(); req = 4'b0000;
        show("b2b2");
        chk("b2_gnt", gnt, 4'b0000);
        chk("b2_rvalid", rvalid, 4'b0001);
        chk("b2_rdata0", rd(0), 8'd110);

        // ptr=1 now: req3 precedes req0 in the scan
        adv(); req = 4'b1001;
        show("wrap");
        chk("w0_rvalid", rvalid, 4'b0000);
        chk("w0_gnt", gnt, 4'b1001);
        chk("w0_addr1", addr1, 10'd1000);
        chk("w0_addr2", addr2, 10'd999);
        adv(); req = 4'b0000;
        show("wrap_data");
        chk("w1_rvalid", rvalid, 4'b1001);
        chk("w1_rdata0", rd(0), 8'd110);
        chk("w1_rdata3", rd(3), 8'd140);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
